// File: rtl/link_tx_arbiter.sv
// -----------------------------------------------------------------------------
// link_tx_arbiter
//
// Shares one FPGA-to-FPGA transmit link between NUM_SRC on-chip producers.
// Ownership of the link is handed out round-robin, one burst of BURST_LEN
// words per grant. Each word is sent with a four-phase req/ack handshake:
// raise tx_req, wait for tx_ack high, drop tx_req, wait for tx_ack low.
// When the burst is complete, tx_sdone pulses for one cycle. If the far end
// stops acknowledging, the burst is aborted and a sticky error flag is set.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-low reset
//   en           arbitration enable, only looked at while idle
//   src_valid    per-source word available
//   src_data     per-source word, source i at [i*DATA_W +: DATA_W]
//   src_ready    per-source word accepted (valid/ready transfer)
//   grant        one-hot current owner, zero when idle
//   link_rdy     far-end receiver ready, only looked at while idle
//   tx_ack       far-end acknowledge
//   tx_req       word request to the far end
//   tx_data      registered link data
//   tx_sdone     one-cycle burst-complete pulse
//   busy         high whenever the arbiter is not idle
//   err_timeout  sticky ack-timeout flag
//   clr_err      synchronous clear of err_timeout (a new timeout wins)
// -----------------------------------------------------------------------------
module link_tx_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 100,
    parameter int TIMEOUT   = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic [NUM_SRC-1:0]        grant,
    input  logic                      link_rdy,
    input  logic                      tx_ack,
    output logic                      tx_req,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_sdone,
    output logic                      busy,
    output logic                      err_timeout,
    input  logic                      clr_err
);

    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_REL,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   owner;       // index of the granted source
    logic [IDX_W-1:0]   rr_ptr;      // first index searched on the next grant
    logic [CNT_W-1:0]   word_cnt;    // words acknowledged in this burst
    logic [TMO_W-1:0]   tmo_cnt;     // cycles spent waiting on one ack edge

    // Round-robin search result
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W:0]     cand;

    // Owner-side views
    logic [DATA_W-1:0]  sel_data;
    logic               owner_valid;
    logic [IDX_W-1:0]   nxt_ptr;
    logic               tmo_hit;

    // FSM strobes into the datapath
    logic               grant_load;
    logic               word_load;
    logic               word_acked;
    logic               release_grant;
    logic               abort;

    // -------------------------------------------------------------------------
    // Round-robin pick: first requester at or after rr_ptr, wrapping modulo
    // NUM_SRC. The sum rr_ptr + k stays below 2*NUM_SRC, so one conditional
    // subtraction is enough to wrap it.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // before any branch; a path that leaves it unassigned infers a latch.
        pick_found = 1'b0;
        pick_idx   = rr_ptr;
        cand       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_SRC)) begin
                cand = cand - (IDX_W+1)'(NUM_SRC);
            end
            if (!pick_found && src_valid[cand[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Data and valid of the current owner
    always_comb begin
        sel_data    = '0;
        owner_valid = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (owner == IDX_W'(i)) begin
                sel_data    = src_data[i*DATA_W +: DATA_W];
                owner_valid = src_valid[i];
            end
        end
    end

    assign nxt_ptr = (owner == IDX_W'(NUM_SRC - 1)) ? '0 : owner + 1'b1;

    // The counter restarts on entry to REQ/REL, so it reads TIMEOUT-1 during
    // the TIMEOUT-th cycle spent waiting on the same ack edge.
    assign tmo_hit = ((state == S_REQ) || (state == S_REL)) &&
                     (tmo_cnt == TMO_W'(TIMEOUT - 1));

    // -------------------------------------------------------------------------
    // Next-state and strobes. An ack edge seen in the last allowed cycle still
    // counts as a handshake; the timeout only fires when it did not arrive.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        grant_load    = 1'b0;
        word_load     = 1'b0;
        word_acked    = 1'b0;
        release_grant = 1'b0;
        abort         = 1'b0;
        case (state)
            S_IDLE: begin
                // link_rdy and en are only sampled here; a running burst
                // ignores both.
                if (en && link_rdy && pick_found) begin
                    grant_load = 1'b1;
                    state_nxt  = S_LOAD;
                end
            end
            S_LOAD: begin
                // A missing word is a producer stall, not a link fault, so it
                // is not timed.
                if (owner_valid) begin
                    word_load = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (tx_ack) begin
                    word_acked = 1'b1;
                    state_nxt  = S_REL;
                end else if (tmo_hit) begin
                    abort         = 1'b1;
                    release_grant = 1'b1;
                    state_nxt     = S_IDLE;
                end
            end
            S_REL: begin
                if (!tx_ack) begin
                    state_nxt = (word_cnt == CNT_W'(BURST_LEN)) ? S_DONE : S_LOAD;
                end else if (tmo_hit) begin
                    abort         = 1'b1;
                    release_grant = 1'b1;
                    state_nxt     = S_IDLE;
                end
            end
            S_DONE: begin
                release_grant = 1'b1;
                state_nxt     = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Only the owner sees ready, and only while a word is being fetched.
    assign src_ready = (state == S_LOAD) ? (grant & src_valid) : '0;
    assign busy      = (state != S_IDLE);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            word_cnt    <= '0;
            tmo_cnt     <= '0;
            grant       <= '0;
            tx_req      <= 1'b0;
            tx_data     <= '0;
            tx_sdone    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state    <= state_nxt;
            // Link pins come straight from flops, decoded from the next state.
            tx_req   <= (state_nxt == S_REQ);
            tx_sdone <= (state_nxt == S_DONE);

            if (((state_nxt == S_REQ) || (state_nxt == S_REL)) && (state_nxt != state)) begin
                tmo_cnt <= '0;
            end else if ((state == S_REQ) || (state == S_REL)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (grant_load) begin
                owner    <= pick_idx;
                grant    <= {{(NUM_SRC-1){1'b0}}, 1'b1} << pick_idx;
                word_cnt <= '0;
            end

            if (word_load) begin
                tx_data <= sel_data;
            end

            // REL leaves for DONE at BURST_LEN, so this never wraps.
            if (word_acked) begin
                word_cnt <= word_cnt + 1'b1;
            end

            // Completed or aborted, the owner drops to lowest priority.
            if (release_grant) begin
                grant  <= '0;
                rr_ptr <= nxt_ptr;
            end

            if (abort) begin
                err_timeout <= 1'b1;
            end else if (clr_err) begin
                err_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: doc/link_tx_arbiter.md
Name: link_tx_arbiter

Overview:
- Shares the single FPGA-to-FPGA transmit link (32-bit data, req/ack/rdy/send_done handshake) between NUM_SRC local data sources.
- Grants the link round-robin, one burst of BURST_LEN words per grant.
- Drives the four-phase req/ack word handshake directly and pulses send_done at the end of each burst.
- Sits between the on-chip producers and the link pins, in place of a single hard-wired sender.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- DATA_W, 32, link data width.
- BURST_LEN, 100, words sent per grant before send_done.
- TIMEOUT, 1024, max cycles spent waiting on one ack edge before abort.

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous active-low reset.
- en  in  1  arbitration enable; when low, no new grant is issued (a running burst completes).
- src_valid  in  NUM_SRC  per-source word available.
- src_data  in  NUM_SRC*DATA_W  per-source word; source i occupies bits [i*DATA_W +: DATA_W].
- src_ready  out  NUM_SRC  per-source word accepted (valid/ready transfer).
- grant  out  NUM_SRC  one-hot current owner; all zero when idle.
- link_rdy  in  1  far-end receiver ready (the rdy line).
- tx_ack  in  1  far-end acknowledge.
- tx_req  out  1  word request.
- tx_data  out  DATA_W  link data, registered.
- tx_sdone  out  1  one-cycle burst-complete pulse (the send_done line).
- busy  out  1  high whenever state != IDLE.
- err_timeout  out  1  sticky ack-timeout flag.
- clr_err  in  1  synchronous clear of err_timeout.

Behaviour:
- Reset values: src_ready=0, grant=0, tx_req=0, tx_data=0, tx_sdone=0, busy=0, err_timeout=0, rr pointer=0, word_cnt=0, state=IDLE. Reset may be asserted in any state; it aborts any burst immediately with no tx_sdone pulse.
- State machine: IDLE, LOAD, REQ, REL, DONE.
- IDLE:
  - If en && link_rdy && |src_valid, grant the first requesting source at or after index rr_ptr (wrapping modulo NUM_SRC).
  - Register the grant and go to LOAD. word_cnt=0.
  - A source that requests with link_rdy low waits; link_rdy is sampled only in IDLE.
- LOAD:
  - src_ready[g] = src_valid[g], combinational and only for the granted source; all other src_ready bits are 0.
  - On src_valid[g]: latch src_data[g] into tx_data and go to REQ.
  - If src_valid[g] is low, stay in LOAD indefinitely; this is a stall, not a timeout.
- REQ:
  - tx_req=1 and tx_data held stable.
  - On tx_ack=1: word_cnt+1, go to REL.
- REL:
  - tx_req=0.
  - On tx_ack=0: if word_cnt==BURST_LEN go to DONE, else go to LOAD.
  - A word therefore costs a minimum of 4 cycles (LOAD, REQ, REL, plus the ack round trip).
- DONE:
  - tx_sdone=1 for exactly one cycle.
  - grant cleared, rr_ptr = g+1 (wrapping from NUM_SRC-1 to 0), go to IDLE.
  - Back-to-back grants are permitted the cycle after DONE.
- Timeout:
  - A counter resets on entry to REQ and REL and increments each cycle spent there.
  - At TIMEOUT: err_timeout=1, tx_req=0, grant cleared, rr_ptr advanced past g, go to IDLE, no tx_sdone.
  - clr_err clears the flag. If a new timeout fires in the same cycle as clr_err, set wins.
- en:
  - en is checked only in IDLE; deasserting en mid-burst has no effect on that burst.
- Simultaneous events:
  - Multiple requesters: round-robin priority only; the grant does not change mid-burst.
  - A source dropping src_valid mid-burst stalls the burst; the grant is held.
- word_cnt width: clog2(BURST_LEN+1); it never wraps.
- tx_data is updated only on a LOAD handshake.

Test Plan:
1. NUM_SRC=4, BURST_LEN=4. Only src1 valid, data 0xFFFFFFFF decrementing; responder acks 2 cycles after req. Expect: grant=0010; 4 req/ack cycles carrying FFFFFFFF, FFFFFFFE, FFFFFFFD, FFFFFFFC; one tx_sdone pulse; grant=0 after.
2. All four sources continuously valid. Expect grant order 0001, 0010, 0100, 1000, 0001; exactly 4 words per grant; tx_sdone once per grant.
3. Responder never raises ack, TIMEOUT=16. Expect tx_req high 16 cycles then low; err_timeout=1; no tx_sdone; next grant goes to the next source. Pulse clr_err and expect err_timeout=0.
4. link_rdy=0 with src2 valid. Expect no grant and busy=0. Raise link_rdy and expect grant=0100 within 1 cycle.
5. src0 drops valid after word 2 for 10 cycles. Expect tx_req low and grant held throughout; burst resumes and completes 4 words; tx_sdone pulses once.
6. Assert rst in REQ mid-burst. Expect all outputs at reset values immediately (asynchronously). After release, arbitration restarts from src0.
